// File: rtl/ps2_key_sequencer.sv
// Folds PS/2 E0/F0 prefixes into complete key events, queues them in a small
// valid/ready FIFO and tracks the held state of the four extended arrow keys.
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clock_fpga,
    input  logic       reset,
    input  logic [7:0] ps2_code,
    input  logic       ps2_new_code,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [3:0] arrow_held,
    output logic       overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } event_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_tmo;
    logic               r_new_d;
    event_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [3:0]         r_arrow;
    logic               r_overflow;

    logic               w_strobe;
    logic               w_is_e0;
    logic               w_is_f0;
    logic               w_is_err;
    logic               w_emit;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    event_t             w_ev;
    event_t             w_head;

    // The receiver holds new_code high for several cycles; only its rising edge counts.
    assign w_strobe = ps2_new_code & ~r_new_d;
    assign w_is_e0  = (ps2_code == 8'hE0);
    assign w_is_f0  = (ps2_code == 8'hF0);
    assign w_is_err = (ps2_code == 8'h00) || (ps2_code == 8'hFF);
    assign w_emit   = w_strobe & ~w_is_e0 & ~w_is_f0 & ~w_is_err;

    assign w_ev.code = ps2_code;
    assign w_ev.ext  = (r_state == S_EXT) || (r_state == S_EXT_BRK);
    assign w_ev.brk  = (r_state == S_BRK) || (r_state == S_EXT_BRK);

    assign w_full = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) & ev_ready;
    assign w_push = w_emit & (~w_full | w_pop);

    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
            r_new_d <= 1'b0;
        end else begin
            r_new_d <= ps2_new_code;
            if (w_strobe) begin
                r_tmo <= '0;
                if (w_is_err) begin
                    r_state <= S_IDLE;
                end else if (w_is_e0) begin
                    case (r_state)
                        S_IDLE:  r_state <= S_EXT;
                        S_BRK:   r_state <= S_EXT_BRK;
                        default: r_state <= r_state;
                    endcase
                end else if (w_is_f0) begin
                    case (r_state)
                        S_IDLE:  r_state <= S_BRK;
                        S_EXT:   r_state <= S_EXT_BRK;
                        default: r_state <= r_state;
                    endcase
                end else begin
                    r_state <= S_IDLE;
                end
            end else if (r_state == S_IDLE) begin
                r_tmo <= '0;
            end else if (r_tmo == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                // A prefix with no follow-up byte is abandoned silently.
                r_state <= S_IDLE;
                r_tmo   <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            // NOTE: storage is reset so the head outputs read 8'h00/0/0 straight out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_ev;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_emit & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Arrow state follows every extended emit, even one the FIFO had to drop.
    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            r_arrow <= 4'h0;
        end else if (w_emit && w_ev.ext) begin
            case (ps2_code)
                8'h75:   r_arrow[0] <= ~w_ev.brk;
                8'h72:   r_arrow[1] <= ~w_ev.brk;
                8'h6B:   r_arrow[2] <= ~w_ev.brk;
                8'h74:   r_arrow[3] <= ~w_ev.brk;
                default: r_arrow    <= r_arrow;
            endcase
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign ev_valid   = (r_count != '0);
    assign ev_code    = w_head.code;
    assign ev_ext     = w_head.ext;
    assign ev_break   = w_head.brk;
    assign arrow_held = r_arrow;
    assign overflow   = r_overflow;

endmodule
